// File: rtl/alu_if.sv
// alu_if: control/datapath bundle between the control unit (master) and the ALU (slave)
interface alu_if;
  logic        Begin;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [13:0] sel;
  logic [15:0] out;
  logic        End;
  logic        output_active;
  logic        co;
  logic        z;
  logic        v;
  logic        n;
  logic [31:0] cc;
  modport master (output Begin, in1, in2, sel, input out, End, output_active, co, z, v, n, cc);
  modport slave (input Begin, in1, in2, sel, output out, End, output_active, co, z, v, n, cc);
endinterface

// File: rtl/alu.sv
// alu: multi-cycle 16-bit ALU; define ALU_MULDIV_EN to build the shift-add multiplier and restoring divider
module alu (
  input logic clk,
  input logic rst_b,
  alu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [15:0] a, b, hi, lo, res, rl, rr;
  logic [13:0] sl;
  logic [16:0] sum, dif, lsl, lsr;
  logic [30:0] rw, rv;
  logic [3:0] k;
  logic c, ov;
  assign a = bus.in1;
  assign b = bus.in2;
  assign k = b[3:0];
  assign sl = bus.sel & (~bus.sel + 14'd1);
  assign bus.cc = {hi, lo};
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    lsl = {1'b0, a} << k;
    lsr = {a, 1'b0} >> k;
    rw = {a, a[15:1]};
    rv = {a[14:0], a};
    rl = rw[5'd30 - {1'b0, k} -: 16];
    rr = rv[k +: 16];
    res = sl[0] ? sum[15:0] : (sl[1] | sl[13]) ? dif[15:0] : sl[5] ? a & b : sl[6] ? a | b :
          sl[7] ? a ^ b : sl[8] ? ~a : sl[9] ? lsl[15:0] : sl[10] ? lsr[16:1] : sl[11] ? rl :
          sl[12] ? rr : |sl[4:2] ? 16'h0000 : a;
    c = sl[0] ? sum[16] : (sl[1] | sl[13]) ? dif[16] : sl[9] ? lsl[16] : sl[10] ? lsr[0] :
        sl[11] ? |k & rl[0] : sl[12] ? |k & rr[15] : 1'b0;
    ov = sl[0] ? (a[15] ~^ b[15]) & (sum[15] ^ a[15]) :
         (sl[1] | sl[13]) ? (a[15] ^ b[15]) & (dif[15] ^ a[15]) : |sl[4:2];
  end
`ifdef ALU_MULDIV_EN
  logic [15:0] mb, nhi, nlo, fin;
  logic [16:0] acc, rem;
  logic [1:0] mop;
  logic [3:0] cnt;
  logic ge;
  // mop = {mod, mul}; neither set means divide
  always_comb begin
    acc = {1'b0, hi} + (lo[0] ? {1'b0, mb} : 17'd0);
    rem = {hi, lo[15]} - {1'b0, mb};
    ge = hi[15] | ~rem[16];
    nhi = mop[0] ? acc[16:1] : ge ? rem[15:0] : {hi[14:0], lo[15]};
    nlo = mop[0] ? {acc[0], lo[15:1]} : {lo[14:0], ge};
    fin = mop[1] ? nhi : nlo;
  end
`endif
  always_ff @(posedge clk)
    if (rst_b) begin
      state <= IDLE;
      hi <= 16'h0;
      lo <= 16'h0;
      bus.out <= 16'h0;
      bus.co <= 1'b0;
      bus.z <= 1'b0;
      bus.v <= 1'b0;
      bus.n <= 1'b0;
      bus.End <= 1'b0;
      bus.output_active <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt <= 4'd0;
`endif
    end else
      case (state)
        IDLE:
          if (bus.Begin) begin
            bus.End <= 1'b0;
`ifdef ALU_MULDIV_EN
            if (|sl[4:2]) begin
              state <= RUN;
              hi <= 16'h0;
              lo <= a;
              mb <= b;
              mop <= {sl[4], sl[2]};
              cnt <= 4'd0;
            end else
`endif
            begin
              state <= DONE;
              bus.out <= res;
              bus.co <= c;
              bus.v <= ov;
              bus.z <= ~|res;
              bus.n <= res[15];
              hi <= 16'h0;
              lo <= res;
              bus.End <= 1'b1;
              bus.output_active <= 1'b1;
            end
          end
`ifdef ALU_MULDIV_EN
        RUN: begin
          hi <= nhi;
          lo <= nlo;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= DONE;
            bus.out <= fin;
            bus.co <= 1'b0;
            bus.v <= mop[0] ? |nhi : ~|mb;
            bus.z <= ~|fin;
            bus.n <= fin[15];
            bus.End <= 1'b1;
            bus.output_active <= 1'b1;
          end
        end
`endif
        DONE: begin
          bus.output_active <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu; expectations are hand-computed constants
module tb_alu;
  localparam logic [13:0] S_ADD = 14'h0001, S_SUB = 14'h0002, S_MUL = 14'h0004, S_DIV = 14'h0008,
                          S_MOD = 14'h0010, S_XOR = 14'h0080, S_NOT = 14'h0100, S_LSL = 14'h0200,
                          S_LSR = 14'h0400, S_ROL = 14'h0800, S_ROR = 14'h1000, S_CMP = 14'h2000;
  logic clk = 1'b0;
  logic rst_b;
  int passed = 0, total = 0, lat, hits;
  alu_if bus();
  alu dut (.clk(clk), .rst_b(rst_b), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic run(input logic [13:0] s, input logic [15:0] a, input logic [15:0] b,
                     input int hold, input int poke, output int l);
    @(negedge clk);
    bus.Begin = 1'b1;
    bus.sel = s;
    bus.in1 = a;
    bus.in2 = b;
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      bus.Begin = (i < hold) || (i == poke);
      bus.in1 = ~a;
      bus.in2 = ~b;
      bus.sel = 14'h0040;
      if (bus.output_active) begin
        l = i;
        break;
      end
    end
  endtask
  task automatic op(input string tag, input logic [13:0] s, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] eo, input logic [3:0] ef, input int el);
    run(s, a, b, 1, 0, lat);
    check({tag, "_lat"}, 32'(lat), 32'(el));
    check({tag, "_out"}, {16'h0, bus.out}, {16'h0, eo});
    check({tag, "_cozvn"}, {28'h0, bus.co, bus.z, bus.v, bus.n}, {28'h0, ef});
  endtask
  task automatic post(input string tag);
    @(negedge clk);
    bus.Begin = 1'b0;
    check({tag, "_oa_end"}, {30'h0, bus.output_active, bus.End}, 32'h1);
  endtask
  task automatic count_oa(input int cycles);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.output_active) hits++;
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_regs"}, {bus.out, 10'h0, bus.co, bus.z, bus.v, bus.n, bus.End, bus.output_active}, 32'h0);
    check({tag, "_cc"}, bus.cc, 32'h0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst_b = 1'b1;
    bus.Begin = 1'b0;
    bus.in1 = 16'h0;
    bus.in2 = 16'h0;
    bus.sel = 14'h0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_b = 1'b0;
    op("add_ovf", S_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 1);
    check("add_cc", bus.cc, 32'h0000_8000);
    post("add_ovf");
    op("add_carry", S_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 1);
    op("sub_eq", S_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b0100, 1);
    op("sub_ovf", S_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0010, 1);
    op("cmp", S_CMP, 16'h0003, 16'h0004, 16'hFFFF, 4'b1001, 1);
    op("lsl", S_LSL, 16'h8001, 16'h0001, 16'h0002, 4'b1000, 1);
    op("lsl_zero", S_LSL, 16'h1234, 16'h0010, 16'h1234, 4'b0000, 1);
    op("lsr", S_LSR, 16'h0003, 16'h0001, 16'h0001, 4'b1000, 1);
    op("rol", S_ROL, 16'h8001, 16'h0001, 16'h0003, 4'b1000, 1);
    op("ror", S_ROR, 16'h0001, 16'h0004, 16'h1000, 4'b0000, 1);
    check("ror_cc", bus.cc, 32'h0000_1000);
    op("xor", S_XOR, 16'hFF00, 16'h0FF0, 16'hF0F0, 4'b0001, 1);
    op("not", S_NOT, 16'h0000, 16'h1234, 16'hFFFF, 4'b0001, 1);
    op("prio", S_ADD | S_XOR | S_CMP, 16'h0003, 16'h0005, 16'h0008, 4'b0000, 1);
    op("pass", 14'h0000, 16'h8000, 16'h0001, 16'h8000, 4'b0001, 1);
    run(S_ADD, 16'h0002, 16'h0003, 2, 0, lat);
    check("hold_lat", 32'(lat), 32'd1);
    check("hold_out", {16'h0, bus.out}, 32'h5);
    post("hold");
    count_oa(5);
    check("hold_single", 32'(hits), 32'd0);
`ifdef ALU_MULDIV_EN
    op("mul", S_MUL, 16'd300, 16'd300, 16'h5F90, 4'b0010, 17);
    check("mul_cc", bus.cc, 32'h0001_5F90);
    post("mul");
    op("div", S_DIV, 16'd100, 16'd7, 16'd14, 4'b0000, 17);
    check("div_cc", bus.cc, 32'h0002_000E);
    op("mod", S_MOD, 16'd100, 16'd7, 16'd2, 4'b0000, 17);
    op("div0", S_DIV, 16'd9, 16'd0, 16'hFFFF, 4'b0011, 17);
    op("mod0", S_MOD, 16'd9, 16'd0, 16'd9, 4'b0010, 17);
    run(S_MUL, 16'd300, 16'd300, 1, 5, lat);
    check("poke_lat", 32'(lat), 32'd17);
    check("poke_out", {16'h0, bus.out}, 32'h5F90);
    post("poke");
    count_oa(20);
    check("poke_single", 32'(hits), 32'd0);
    @(negedge clk);
    bus.Begin = 1'b1;
    bus.sel = S_MUL;
    bus.in1 = 16'd300;
    bus.in2 = 16'd300;
    @(negedge clk);
    bus.Begin = 1'b0;
    repeat (7) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check_reset("mid_rst");
    count_oa(25);
    check("mid_rst_no_oa", 32'(hits), 32'd0);
`else
    op("mul_off", S_MUL, 16'd300, 16'd300, 16'h0000, 4'b0110, 1);
    check("mul_off_cc", bus.cc, 32'h0);
    op("div_off", S_DIV, 16'd100, 16'd7, 16'h0000, 4'b0110, 1);
    op("mod_off", S_MOD, 16'd100, 16'd7, 16'h0000, 4'b0110, 1);
    op("xor_after", S_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000, 1);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check_reset("rst_after");
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu.md
# alu

Multi-cycle 16-bit arithmetic/logic unit of the processor datapath. It is started by the control unit with a one-cycle `Begin` strobe and operates on two operands. It returns a registered result plus N/Z/C/V flags, with a one-cycle completion strobe that loads the datapath result register. Its internal working registers are exported for observation.

## Interface
Parameters:
- None. The width is fixed at 16 bits.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_b`  in  1  — reset, synchronous, active-high.
- `Begin`  in  1  — start strobe; sampled only in IDLE.
- `in1`  in  16  — operand A (accumulator or PC+1).
- `in2`  in  16  — operand B (X/Y or immediate).
- `sel`  in  14  — one-hot operation select; the lowest set bit wins.
- `out`  out  16  — registered result.
- `End`  out  1  — level; high from completion until the next accepted `Begin`.
- `output_active`  out  1  — one-cycle strobe; `out` and the flags are valid in this cycle.
- `co`, `z`, `v`, `n`  out  1 each  — carry/borrow, zero, overflow, negative.
- `cc`  out  32  — internal working registers {hi, lo}.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE with `Begin`=1: latch `in1`, `in2`, `sel`, then go to RUN. Single-cycle ops go straight to DONE.
  - DONE lasts one cycle, asserts `output_active`, sets `End`, and returns to IDLE.
- `sel` bit encodings:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 MUL: low 16 bits of A×B, unsigned.
  - 3 DIV: A/B, unsigned.
  - 4 MOD: A%B, unsigned.
  - 5 AND, 6 OR, 7 XOR.
  - 8 NOT: ~A.
  - 9 LSL, 10 LSR, 11 ROL, 12 ROR: shift/rotate A by B[3:0].
  - 13 CMP: out=A−B, with flags as for SUB.
  - `sel`=0: out=A, co=v=0.
- Flags are updated only at completion and held otherwise.
  - z = (out==0).
  - n = out[15].
  - ADD: co = carry out; v = signed overflow.
  - SUB/CMP: co = borrow (A<B unsigned); v = signed overflow.
  - MUL: co=0; v = (high 16 bits of the product ≠ 0).
  - DIV/MOD: co=0; v=0 except on divide-by-zero.
  - Logic ops: co=v=0.
  - Shifts: co = last bit shifted out; v=0. A shift amount of 0 gives out=A and co=0.
- MUL uses shift-add over 16 iterations; cc = {partial product hi, multiplier/product lo}.
- DIV/MOD uses restoring division over 16 iterations; cc = {remainder, quotient}.
- Divide by zero: DIV gives out=16'hFFFF, MOD gives out=A, and v=1. It takes the same 17-cycle latency.
- Single-cycle ops: cc = {16'h0000, result}.
- `Begin` in RUN or DONE is ignored. There is no queueing.

## Timing
- Reset (rst_b=1 at an edge) puts the unit in IDLE with out=0, co=z=v=n=0, cc=0, End=0, output_active=0. This takes effect from any state, including mid-MUL/DIV, and the operation is discarded.
- Single-cycle ops: `Begin` at edge k gives `output_active`=1 during cycle k+1.
- MUL/DIV/MOD: `Begin` at edge k gives 16 RUN cycles, then `output_active`=1 during cycle k+17.
- `output_active` is exactly one cycle wide per accepted `Begin`. `End` rises with it and clears on the edge that accepts the next `Begin`.
- Back-to-back: a new `Begin` is accepted in the cycle after DONE, i.e. when the unit is back in IDLE.
- Operands may change after the `Begin` edge without affecting the result.

## Configuration
- `ALU_MULDIV_EN` defined: MUL, DIV and MOD are implemented as specified.
- `ALU_MULDIV_EN` undefined: no multiplier/divider hardware is built. `sel` bits 2–4 complete in 1 cycle with out=0, v=1, co=0, z=1, n=0; cc stays 0.

## Test plan
- ADD 16'h7FFF+16'h0001: `output_active` 1 cycle after `Begin`; out=16'h8000, n=1, v=1, co=0, z=0.
- SUB 5−5: out=0, z=1, co=0, v=0. CMP 3−4: out=16'hFFFF, co=1, n=1.
- MUL 300×300 (with macro): `output_active` exactly 17 cycles after `Begin`; out=16'h5F90, v=1; cc[15:0]=16'h5F90, cc[31:16]=16'h0001.
- DIV 100/7 gives out=14. MOD 100/7 gives out=2. DIV 9/0 gives out=16'hFFFF with v=1 after 17 cycles.
- Assert `Begin` again mid-MUL: ignored, single `output_active`. Assert rst_b at cycle 8 of a MUL: out, flags and cc go to 0 and no `output_active` follows.
- LSL 16'h8001 by 1: out=16'h0002, co=1. ROR 16'h0001 by 4: out=16'h1000.
